// File: rtl/bus_pkg.sv
// Shared bus definitions for the SRAM-like to AXI4 bridges.
// Holds the AXI response codes, the MEM-side transfer size encodings and the
// bridge state enumeration.
package bus_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    // AXI response codes
    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] EXOKAY = 2'd1;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    // MEM-side transfer size encodings (log2 of byte count)
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4
    } bridge_state_t;

endpackage

// File: rtl/wstrb_gen.sv
// Byte-lane strobe generator: maps (size, addr[1:0]) to a 4-bit write strobe.
// Ports:
//   size   in  2  SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   offset in  2  low address bits
//   wstrb  out 4  combinational byte-lane enables
// Lanes shifted past bit 3 are dropped; words always enable all lanes.
module wstrb_gen
    import bus_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    output logic [STRB_W-1:0] wstrb
);

    always_comb begin
        wstrb = '1;
        case (size)
            SIZE_BYTE: wstrb = 4'b0001 << offset;
            SIZE_HALF: wstrb = 4'b0011 << offset;
            default:   wstrb = '1;
        endcase
    end

endmodule

// File: rtl/data_axi_bridge.sv
// Data-side bridge: MEM stage SRAM-like bus -> single-beat AXI4 read/write.
// One transaction outstanding at a time.
// Ports:
//   clk, rst                      clock, async active-high reset
//   data_req/wr/size/addr/wdata   request from MEM
//   data_addr_ok                  request accepted this cycle (comb)
//   data_data_ok, data_rdata      completion pulse and load data (comb)
//   ar*/r*                        AXI read address / read data channels
//   aw*/w*/b*                     AXI write address / data / response channels
//   data_err                      registered error pulse (only with DATA_AXI_BUS_ERR_EN)
// Optional feature macro: DATA_AXI_BUS_ERR_EN adds SLVERR/DECERR reporting.
module data_axi_bridge
    import bus_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  ADDR_MASK  = ADDR_WIDTH'(32'hFFFF_FFFF)
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [1:0]            data_size,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arsize,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awsize,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [STRB_W-1:0]     wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
`ifdef DATA_AXI_BUS_ERR_EN
    output logic                  data_err,
`endif
    output logic                  bready
);

    bridge_state_t         state_q;
    bridge_state_t         state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [STRB_W-1:0]     strb_q;
    logic [STRB_W-1:0]     strb_c;
    logic                  aw_done;
    logic                  w_done;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  aw_all;
    logic                  w_all;

    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    // A channel counts as done if it completed earlier or completes now
    assign aw_all = aw_done | aw_hs;
    assign w_all  = w_done | w_hs;

    wstrb_gen u_wstrb_gen (
        .size   (data_size),
        .offset (data_addr[1:0]),
        .wstrb  (strb_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_req) state_d = data_wr ? WR_REQ : RD_ADDR;
            RD_ADDR: if (arready)  state_d = RD_DATA;
            RD_DATA: if (rvalid)   state_d = IDLE;
            WR_REQ:  if (aw_all && w_all) state_d = WR_RESP;
            WR_RESP: if (bvalid)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Combinational MEM-side handshakes and AXI ready signals
    always_comb begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = '0;
        rready       = 1'b0;
        bready       = 1'b0;
        case (state_q)
            IDLE:    data_addr_ok = data_req;
            RD_DATA: begin
                rready       = 1'b1;
                data_data_ok = rvalid;
                data_rdata   = rvalid ? rdata : '0;
            end
            WR_RESP: begin
                bready       = 1'b1;
                data_data_ok = bvalid;
            end
            default: ;
        endcase
    end

    // Request latch and registered AXI valids
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            arvalid <= 1'b0;
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
        end else if (data_addr_ok) begin
            addr_q  <= data_addr & ADDR_MASK;
            size_q  <= data_size;
            wdata_q <= data_wdata;
            strb_q  <= strb_c;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            arvalid <= ~data_wr;
            awvalid <= data_wr;
            wvalid  <= data_wr;
        end else begin
            if (arvalid && arready) arvalid <= 1'b0;
            if (aw_hs) begin
                awvalid <= 1'b0;
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                wvalid <= 1'b0;
                w_done <= 1'b1;
            end
        end
    end

    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awsize = {1'b0, size_q};
    assign wdata  = wdata_q;
    assign wstrb  = strb_q;

`ifdef DATA_AXI_BUS_ERR_EN
    logic [1:0] resp_c;
    logic       resp_err_c;

    assign resp_c     = (state_q == RD_DATA) ? rresp : bresp;
    assign resp_err_c = (resp_c == SLVERR) || (resp_c == DECERR);

    // Error pulse lands the cycle after the failing completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_err <= 1'b0;
        end else begin
            data_err <= data_data_ok & resp_err_c;
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};
`endif

endmodule

// File: tb/tb_data_axi_bridge.sv
// Self-checking bench for data_axi_bridge: directed scenarios plus randomized
// transactions against a transaction-level reference model.
module tb_data_axi_bridge;

    localparam int unsigned AW   = 32;
    localparam logic [31:0] MASK = 32'h3FFF_FFFF;

    logic          clk;
    logic          rst;
    logic          data_req;
    logic          data_wr;
    logic [1:0]    data_size;
    logic [AW-1:0] data_addr;
    logic [31:0]   data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [31:0]   data_rdata;
    logic [AW-1:0] araddr;
    logic [2:0]    arsize;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic [AW-1:0] awaddr;
    logic [2:0]    awsize;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
`ifdef DATA_AXI_BUS_ERR_EN
    logic          data_err;
    bit            err_due;
`endif

    int tests_run;
    int tests_failed;

    data_axi_bridge #(.ADDR_WIDTH(AW), .ADDR_MASK(MASK)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .awaddr       (awaddr),
        .awsize       (awsize),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
`ifdef DATA_AXI_BUS_ERR_EN
        .data_err     (data_err),
`endif
        .bready       (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Lanes covered by a transfer of 2**size bytes starting at the byte offset
    function automatic logic [3:0] model_strb(input logic [1:0] size, input logic [1:0] off);
        int n;
        int first;
        logic [3:0] s;
        n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        first = (size == 2'd2) ? 0 : int'(off);
        s     = '0;
        for (int j = 0; j < 4; j++)
            if (j >= first && j < first + n) s[j] = 1'b1;
        return s;
    endfunction

    task automatic drive_idle();
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_size  = 2'd0;
        data_addr  = '0;
        data_wdata = '0;
        arready    = 1'b0;
        rvalid     = 1'b0;
        rdata      = '0;
        rresp      = 2'd0;
        awready    = 1'b0;
        wready     = 1'b0;
        bvalid     = 1'b0;
        bresp      = 2'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_araddr"},  araddr, 0);
        check({tag, "_arsize"},  arsize, 0);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_rready"},  rready, 0);
        check({tag, "_awaddr"},  awaddr, 0);
        check({tag, "_awvalid"}, awvalid, 0);
        check({tag, "_wvalid"},  wvalid, 0);
        check({tag, "_wdata"},   wdata, 0);
        check({tag, "_wstrb"},   wstrb, 0);
        check({tag, "_bready"},  bready, 0);
        check({tag, "_addr_ok"}, data_addr_ok, 0);
        check({tag, "_data_ok"}, data_data_ok, 0);
        check({tag, "_rdata"},   data_rdata, 0);
`ifdef DATA_AXI_BUS_ERR_EN
        check({tag, "_err"},     data_err, 0);
`endif
    endtask

    // One idle cycle: no request, no slave activity
    task automatic idle_cycle();
        @(negedge clk);
        drive_idle();
        #1;
        check("idle_data_ok", data_data_ok, 0);
`ifdef DATA_AXI_BUS_ERR_EN
        check("idle_err", data_err, err_due);
        err_due = 1'b0;
`endif
    endtask

    // Full transaction: bench plays both the MEM master and the AXI slave.
    // Delays are cycles a valid waits for ready; r_dly/b_dly (>=1) are cycles
    // from the last request handshake to the response valid.
    task automatic do_txn(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] resp,
                          input int ar_dly, input int r_dly, input int aw_dly, input int w_dly,
                          input int b_dly, input bit hold);
        int cyc;
        int exp_done;
        int ar_seen, aw_seen, w_seen;
        int ar_cnt, aw_cnt, w_cnt, ok_cnt;
        int ar_cyc, aw_cyc, w_cyc;
        bit accepted, done;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        cyc = 0; ar_seen = 0; aw_seen = 0; w_seen = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; ok_cnt = 0;
        ar_cyc = 0; aw_cyc = 0; w_cyc = 0;
        accepted = 1'b0; done = 1'b0;
        exp_addr = addr & MASK;
        exp_strb = model_strb(size, addr[1:0]);
        exp_done = wr ? 1 + imax(aw_dly, w_dly) + b_dly : 1 + ar_dly + r_dly;
        while (!done && cyc < 64) begin
            @(negedge clk);
            data_req   = hold | ~accepted;
            data_wr    = wr;
            data_size  = size;
            data_addr  = addr;
            data_wdata = wd;
            arready = arvalid && (ar_seen >= ar_dly);
            awready = awvalid && (aw_seen >= aw_dly);
            wready  = wvalid && (w_seen >= w_dly);
            rvalid  = (ar_cnt > 0) && (cyc >= ar_cyc + r_dly);
            bvalid  = (aw_cnt > 0) && (w_cnt > 0) && (cyc >= imax(aw_cyc, w_cyc) + b_dly);
            rdata   = rvalid ? rd : $urandom;
            rresp   = resp;
            bresp   = resp;
            #1;
`ifdef DATA_AXI_BUS_ERR_EN
            check("err_pulse", data_err, err_due);
            err_due = 1'b0;
`endif
            if (data_addr_ok) begin
                ok_cnt++;
                if (!accepted) check("accept_cycle", cyc, 0);
                accepted = 1'b1;
            end
            if (arvalid) begin
                if (arready) begin
                    check("araddr", araddr, exp_addr);
                    check("arsize", arsize, {1'b0, size});
                    ar_cnt++;
                    ar_cyc = cyc;
                end
                ar_seen++;
            end
            if (awvalid) begin
                if (awready) begin
                    check("awaddr", awaddr, exp_addr);
                    check("awsize", awsize, {1'b0, size});
                    aw_cnt++;
                    aw_cyc = cyc;
                end
                aw_seen++;
            end
            if (wvalid) begin
                if (wready) begin
                    check("wdata", wdata, wd);
                    check("wstrb", wstrb, exp_strb);
                    w_cnt++;
                    w_cyc = cyc;
                end
                w_seen++;
            end
            if (data_data_ok) begin
                check("rdata", data_rdata, wr ? 32'h0 : rd);
                check("done_cycle", cyc, exp_done);
                check("ok_overlap", data_addr_ok, 0);
                check("resp_ready", wr ? bready : rready, 1);
`ifdef DATA_AXI_BUS_ERR_EN
                err_due = resp[1];
`endif
                done = 1'b1;
            end
            cyc++;
        end
        check("txn_done", done, 1);
        check("addr_ok_count", ok_cnt, 1);
        check("ar_hs_count", ar_cnt, wr ? 0 : 1);
        check("aw_hs_count", aw_cnt, wr ? 1 : 0);
        check("w_hs_count", w_cnt, wr ? 1 : 0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
`ifdef DATA_AXI_BUS_ERR_EN
        err_due = 1'b0;
`endif
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        idle_cycle();

        // LW, immediate arready, rvalid two cycles after AR handshake
        do_txn(1'b0, 2'd2, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 2'd0, 0, 2, 0, 0, 1, 1'b0);
        idle_cycle();
        // SB, awready three cycles ahead of wready
        do_txn(1'b1, 2'd0, 32'h0000_2003, 32'h5A5A_5A5A, 32'h0, 2'd0, 0, 1, 0, 3, 1, 1'b0);
        idle_cycle();
        // SH, both write handshakes in the same cycle
        do_txn(1'b1, 2'd1, 32'h0000_3002, 32'h1234_5678, 32'h0, 2'd0, 0, 1, 0, 0, 2, 1'b0);
        // data_req held through a read, then accepted right after completion
        do_txn(1'b0, 2'd2, 32'h0000_4000, 32'h0, 32'hCAFE_F00D, 2'd0, 1, 2, 0, 0, 1, 1'b1);
        do_txn(1'b0, 2'd0, 32'h0000_4001, 32'h0, 32'h0000_00A5, 2'd0, 0, 1, 0, 0, 1, 1'b0);
        idle_cycle();

        // Reset while waiting in RD_DATA
        @(negedge clk);
        drive_idle();
        data_req  = 1'b1;
        data_size = 2'd2;
        data_addr = 32'h0000_5000;
        #1;
        check("rst_accept", data_addr_ok, 1);
        @(negedge clk);
        drive_idle();
        arready = 1'b1;
        #1;
        check("rst_arvalid", arvalid, 1);
        @(negedge clk);
        drive_idle();
        #1;
        check("rst_rready_before", rready, 1);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
`ifdef DATA_AXI_BUS_ERR_EN
        err_due = 1'b0;
`endif
        @(negedge clk);
        rvalid = 1'b1;
        rdata  = 32'h1111_2222;
        #1;
        check("late_rvalid_ok", data_data_ok, 0);
        check("late_rvalid_rdy", rready, 0);
        idle_cycle();

`ifdef DATA_AXI_BUS_ERR_EN
        // SW with SLVERR: completion then one-cycle error pulse
        do_txn(1'b1, 2'd2, 32'h0000_6000, 32'hFFFF_0000, 32'h0, 2'd2, 0, 1, 1, 0, 1, 1'b0);
        idle_cycle();
        idle_cycle();
`endif

        // Randomized transactions
        for (int t = 0; t < 60; t++) begin
            bit         wr;
            logic [1:0] sz;
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            do_txn(wr, sz, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(1, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
